mvm_stream_core: RTL and testbench



---
 rtl/mvm_stream_pkg.sv | 19 +
 rtl/mvm_stream_if.sv | 16 +
 rtl/mvm_mac.sv | 31 +++
 rtl/mvm_stream_core.sv | 179 +++++++++++++++++
 tb/tb_mvm_stream_core.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_stream_pkg.sv
// mvm_stream_pkg: shared FSM states, header bit positions and width helpers for the MVM stream core.
//   acc_width(): accumulator width that holds a full C-term dot product without overflow.
//   idx_width(): counter width for indexing n entries (at least 1 bit).
package mvm_stream_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_X, COMPUTE, SEND} state_t;

    localparam int HDR_LOAD_K = 0;
    localparam int HDR_SIGNED = 1;

    function automatic int acc_width(int w_x, int w_k, int c);
        return w_x + w_k + $clog2(c) + 1;
    endfunction

    function automatic int idx_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_stream_if.sv
// mvm_stream_if: byte stream pair between the UART RX/TX side and the MVM core.
//   s_data/s_valid/s_ready : inbound byte stream (header, K, x)
//   m_data/m_valid/m_ready : outbound byte stream (y, LSB first)
//   master : the side that feeds bytes in and drains bytes out
//   slave  : the core
interface mvm_stream_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid);
    modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/mvm_mac.sv
// mvm_mac: extends one K and one x element (signed or unsigned) and adds their product to an accumulator.
//   k_i, x_i : raw element bits
//   sgn_i    : 1 = sign-extend both operands, 0 = zero-extend
//   clr_i    : start a new row (ignore acc_i)
//   acc_i    : running sum
//   acc_o    : running sum plus k*x
module mvm_mac
    import mvm_stream_pkg::*;
#(
    parameter int W_X = 4,
    parameter int W_K = 4,
    parameter int C   = 2,
    parameter int W_A = acc_width(W_X, W_K, C)
) (
    input  logic [W_K-1:0] k_i,
    input  logic [W_X-1:0] x_i,
    input  logic           sgn_i,
    input  logic           clr_i,
    input  logic [W_A-1:0] acc_i,
    output logic [W_A-1:0] acc_o
);
    logic [W_A-1:0] k_ext;
    logic [W_A-1:0] x_ext;

    // Two's-complement product truncated to W_A is exact because W_A exceeds the full product width.
    always_comb begin
        k_ext = sgn_i ? W_A'($signed(k_i)) : W_A'(k_i);
        x_ext = sgn_i ? W_A'($signed(x_i)) : W_A'(x_i);
        acc_o = (clr_i ? '0 : acc_i) + k_ext * x_ext;
    end
endmodule

// File: rtl/mvm_stream_core.sv
// mvm_stream_core: byte-stream y = K*x engine with matrix reuse, runtime signed mode and output backpressure.
//   clk, rstn : clock, asynchronous active-low reset
//   s         : mvm_stream_if.slave (inbound header/K/x bytes, outbound y bytes)
//   busy      : high outside IDLE
//   k_loaded  : a matrix has been stored since reset
// Build option: define MVM_SATURATE_EN to clamp each y element instead of wrapping it.
module mvm_stream_core
    import mvm_stream_pkg::*;
#(
    parameter int R       = 2,
    parameter int C       = 2,
    parameter int W_X     = 4,
    parameter int W_K     = 4,
    parameter int W_Y_OUT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    mvm_stream_if.slave   s,
    output logic          busy,
    output logic          k_loaded
);
    localparam int NK = R * C;
    localparam int BY = (W_Y_OUT + 7) / 8;
    localparam int YP = BY * 8;
    localparam int WA = acc_width(W_X, W_K, C);
    localparam int IW = idx_width(NK);
    localparam int CW = idx_width(C);
    localparam int RW = idx_width(R);
    localparam int BW = idx_width(BY);

    state_t          st_q, st_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [BW-1:0]   byt_q, byt_d;
    logic            sgn_q, sgn_d;
    logic            kl_q, kl_d;
    logic [WA-1:0]   acc_q;
    logic [WA-1:0]   mac_sum;
    logic [W_K-1:0]  k_q [NK];
    logic [W_X-1:0]  x_q [C];
    logic [W_Y_OUT-1:0] y_q [R];
    logic [W_Y_OUT-1:0] y_new;
    logic [YP-1:0]   y_pad;
    logic            k_we, x_we, y_we, hs_in, hs_out;
    logic            unused_hdr_bits;

    assign unused_hdr_bits = ^s.s_data;

    mvm_mac #(.W_X(W_X), .W_K(W_K), .C(C), .W_A(WA)) u_mac (
        .k_i   (k_q[idx_q]),
        .x_i   (x_q[col_q]),
        .sgn_i (sgn_q),
        .clr_i (col_q == '0),
        .acc_i (acc_q),
        .acc_o (mac_sum)
    );

`ifdef MVM_SATURATE_EN
    localparam logic signed [63:0] HI_S = (64'sd1 <<< (W_Y_OUT - 1)) - 64'sd1;
    localparam logic signed [63:0] HI_U = (64'sd1 <<< W_Y_OUT) - 64'sd1;
    localparam logic signed [63:0] LO_S = -(64'sd1 <<< (W_Y_OUT - 1));
    logic signed [63:0] a64, hi, lo;

    always_comb begin
        a64   = sgn_q ? 64'($signed(mac_sum)) : 64'(mac_sum);
        hi    = sgn_q ? HI_S : HI_U;
        lo    = sgn_q ? LO_S : 64'sd0;
        y_new = a64 > hi ? W_Y_OUT'(hi) : a64 < lo ? W_Y_OUT'(lo) : W_Y_OUT'(a64);
    end
`else
    assign y_new = sgn_q ? W_Y_OUT'($signed(mac_sum)) : W_Y_OUT'(mac_sum);
`endif

    // Padding above W_Y_OUT in the last byte follows the transaction's signedness.
    assign y_pad = sgn_q ? YP'($signed(y_q[row_q])) : YP'(y_q[row_q]);

    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        col_d = col_q;
        row_d = row_q;
        byt_d = byt_q;
        sgn_d = sgn_q;
        kl_d  = kl_q;
        k_we  = 1'b0;
        x_we  = 1'b0;
        y_we  = 1'b0;
        s.s_ready = rstn && (st_q == IDLE || st_q == LOAD_K || st_q == LOAD_X);
        s.m_valid = st_q == SEND;
        s.m_data  = st_q == SEND ? y_pad[8*byt_q +: 8] : 8'h00;
        busy      = st_q != IDLE;
        k_loaded  = kl_q;
        hs_in     = s.s_valid && s.s_ready;
        hs_out    = s.m_valid && s.m_ready;
        case (st_q)
            IDLE: if (hs_in) begin
                sgn_d = s.s_data[HDR_SIGNED];
                idx_d = '0;
                col_d = '0;
                st_d  = s.s_data[HDR_LOAD_K] ? LOAD_K : LOAD_X;
            end
            LOAD_K: if (hs_in) begin
                k_we  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NK - 1)) begin
                    idx_d = '0;
                    kl_d  = 1'b1;
                    st_d  = LOAD_X;
                end
            end
            LOAD_X: if (hs_in) begin
                x_we  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == CW'(C - 1)) begin
                    col_d = '0;
                    idx_d = '0;
                    row_d = '0;
                    st_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                idx_d = idx_q + 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == CW'(C - 1)) begin
                    col_d = '0;
                    y_we  = 1'b1;
                    row_d = row_q + 1'b1;
                end
                if (idx_q == IW'(NK - 1)) begin
                    idx_d = '0;
                    row_d = '0;
                    byt_d = '0;
                    st_d  = SEND;
                end
            end
            SEND: if (hs_out) begin
                byt_d = byt_q + 1'b1;
                if (byt_q == BW'(BY - 1)) begin
                    byt_d = '0;
                    row_d = row_q + 1'b1;
                    if (row_q == RW'(R - 1)) begin
                        row_d = '0;
                        st_d  = IDLE;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q  <= IDLE;
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
            byt_q <= '0;
            sgn_q <= 1'b0;
            kl_q  <= 1'b0;
            acc_q <= '0;
            for (int i = 0; i < NK; i++) k_q[i] <= '0;
            for (int i = 0; i < C; i++) x_q[i] <= '0;
            for (int i = 0; i < R; i++) y_q[i] <= '0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            col_q <= col_d;
            row_q <= row_d;
            byt_q <= byt_d;
            sgn_q <= sgn_d;
            kl_q  <= kl_d;
            if (st_q == COMPUTE) acc_q <= mac_sum;
            if (k_we) k_q[idx_q] <= s.s_data[W_K-1:0];
            if (x_we) x_q[col_q] <= s.s_data[W_X-1:0];
            if (y_we) y_q[row_q] <= y_new;
        end
    end
endmodule

// File: tb/tb_mvm_stream_core.sv
// tb_mvm_stream_core: directed vector table, randomized transactions against an arithmetic model, backpressure and reset corner cases.
module tb_mvm_stream_core;
    localparam int R = 2, C = 2, W_X = 4, W_K = 4, W_Y_OUT = 8;
    localparam int NK = R * C;
    localparam int BY = (W_Y_OUT + 7) / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic busy, k_loaded;
    mvm_stream_if bus();

    mvm_stream_core #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y_OUT)) dut (
        .clk(clk), .rstn(rstn), .s(bus), .busy(busy), .k_loaded(k_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model state: stored matrix and whether one was loaded.
    logic [7:0] mk [NK];
    bit         mkl;
    logic [7:0] hdr_g;
    logic [7:0] kb [NK];
    logic [7:0] xb [C];
    logic [7:0] exp_q [$];

    function automatic longint ext(input logic [7:0] v, input int w, input bit sg);
        longint m = longint'(v) & ((longint'(1) << w) - 1);
        return (sg && m >= (longint'(1) << (w - 1))) ? m - (longint'(1) << w) : m;
    endfunction

    task automatic prep();
        if (hdr_g[0]) begin
            mk  = kb;
            mkl = 1'b1;
        end
    endtask

    task automatic model_expect();
        bit sg = hdr_g[1];
        longint acc, hi, lo;
        for (int r = 0; r < R; r++) begin
            acc = 0;
            for (int c = 0; c < C; c++) acc += ext(mk[r*C+c], W_K, sg) * ext(xb[c], W_X, sg);
`ifdef MVM_SATURATE_EN
            hi = sg ? (longint'(1) << (W_Y_OUT - 1)) - 1 : (longint'(1) << W_Y_OUT) - 1;
            lo = sg ? -(longint'(1) << (W_Y_OUT - 1)) : 0;
            acc = acc > hi ? hi : acc < lo ? lo : acc;
`else
            hi = 0;
            lo = 0;
            acc = acc & ((longint'(1) << W_Y_OUT) - 1);
            if (sg && acc >= (longint'(1) << (W_Y_OUT - 1))) acc -= longint'(1) << W_Y_OUT;
`endif
            for (int b = 0; b < BY; b++) exp_q.push_back(8'(acc >>> (8 * b)));
        end
    endtask

    // Called 1 time unit after a rising edge; returns the cycle in which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, output int t);
        int n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
    endtask

    task automatic send_input(output int t);
        send_byte(hdr_g, t);
        if (hdr_g[0]) for (int i = 0; i < NK; i++) send_byte(kb[i], t);
        for (int i = 0; i < C; i++) send_byte(xb[i], t);
    endtask

    // bp: 0 = always ready, 1 = random ready, 2 = stall the first 5 valid cycles
    task automatic run_txn(input int bp);
        int t, n = 0, got = 0, first = -1, held = 0;
        int nb = exp_q.size();
        bit stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        send_input(t);
        bus.m_ready = (bp == 0);
        while (got < nb && n < 500) begin
            @(negedge clk);
            n++;
            if (bus.m_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk("latency", 32'(cyc - t), 32'(1 + R * C));
                end
                chk("s_ready_in_send", 32'(bus.s_ready), 32'd0);
                if (stalled) chk("hold_data", 32'(bus.m_data), 32'(prev));
                if (bus.m_ready) begin
                    chk($sformatf("y_byte%0d", got), 32'(bus.m_data), 32'(exp_q[got]));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev = bus.m_data;
                    held++;
                end
            end else if (first >= 0) chk("m_valid_gap", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            bus.m_ready = bp == 0 ? 1'b1 : bp == 1 ? 1'($urandom_range(0, 1)) : (held >= 5);
        end
        if (got < nb) chk("recv_timeout", 32'(got), 32'(nb));
        chk("idle_s_ready", 32'(bus.s_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        bus.m_ready = 1'b0;
        exp_q.delete();
    endtask

    typedef struct packed {
        logic [7:0]             hdr;
        logic [0:NK-1][7:0]     k;
        logic [0:C-1][7:0]      x;
        logic [0:R-1][7:0]      y;
        logic [1:0]             bp;
    } vec_t;

`ifdef MVM_SATURATE_EN
    localparam logic [7:0] OVF = 8'hFF;
`else
    localparam logic [7:0] OVF = 8'hC2;
`endif

    vec_t tab [4];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tab[0] = '{hdr: 8'h01, k: {8'h01, 8'h02, 8'h03, 8'h04}, x: {8'h05, 8'h06}, y: {8'h11, 8'h27}, bp: 2'd0};
        tab[1] = '{hdr: 8'h00, k: {8'h00, 8'h00, 8'h00, 8'h00}, x: {8'h01, 8'h01}, y: {8'h03, 8'h07}, bp: 2'd2};
        tab[2] = '{hdr: 8'h03, k: {8'h0F, 8'h02, 8'h03, 8'h0C}, x: {8'h02, 8'h0D}, y: {8'hF8, 8'h12}, bp: 2'd0};
        tab[3] = '{hdr: 8'h01, k: {8'h0F, 8'h0F, 8'h0F, 8'h0F}, x: {8'h0F, 8'h0F}, y: {OVF, OVF}, bp: 2'd2};
        for (int i = 0; i < NK; i++) mk[i] = 8'h00;
        mkl = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        #12;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_k_loaded", 32'(k_loaded), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_s_ready_after_rst", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            hdr_g = tab[v].hdr;
            for (int i = 0; i < NK; i++) kb[i] = tab[v].k[i];
            for (int i = 0; i < C; i++) xb[i] = tab[v].x[i];
            for (int r = 0; r < R; r++) exp_q.push_back(tab[v].y[r]);
            prep();
            run_txn(int'(tab[v].bp));
            chk($sformatf("vec%0d_k_loaded", v), 32'(k_loaded), 32'd1);
        end

        for (int n = 0; n < 30; n++) begin
            hdr_g = 8'($urandom);
            for (int i = 0; i < NK; i++) kb[i] = 8'($urandom);
            for (int i = 0; i < C; i++) xb[i] = 8'($urandom);
            prep();
            model_expect();
            run_txn(1);
            chk("rand_k_loaded", 32'(k_loaded), 32'(mkl));
        end

        // Abort during the first output byte: everything returns to reset values at once.
        hdr_g = 8'h01;
        for (int i = 0; i < NK; i++) kb[i] = 8'($urandom_range(1, 15));
        for (int i = 0; i < C; i++) xb[i] = 8'($urandom_range(1, 15));
        send_input(t);
        bus.m_ready = 1'b0;
        for (int n = 0; n < 50 && !bus.m_valid; n++) @(negedge clk);
        chk("pre_abort_m_valid", 32'(bus.m_valid), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_k_loaded", 32'(k_loaded), 32'd0);
        chk("abort_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < NK; i++) mk[i] = 8'h00;
        mkl = 1'b0;
        hdr_g = 8'h00;
        xb[0] = 8'h03;
        xb[1] = 8'h03;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        run_txn(0);
        chk("nok_k_loaded", 32'(k_loaded), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
